// File: rtl/inst_fetch_unit_if.sv
// Bundle of fetch-side handshakes: redirect, memory request/response, and the decode-facing instruction stream.
// The fetch unit takes the master modport; the memory/decode environment takes the slave modport.
interface inst_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] PCC;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, PCC
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, PCC
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: one outstanding memory read, credit-limited so responses always fit the
// instruction FIFO, with branch redirect that flushes the FIFO and drops any in-flight response.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2  // 2 or 4
) (
  input  logic               CLK,
  input  logic               rst,
  inst_fetch_unit_if.master  bus
);
  localparam int unsigned   PW      = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   req_pc_q;
  logic          mem_req_valid_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic accept;
  logic push;
  logic pop;
  logic head_valid;
  logic unused_redirect_lsbs;

  assign accept     = mem_req_valid_q & bus.mem_req_ready;
  // Responses outside WAIT (or colliding with a redirect) never reach the FIFO.
  assign push       = (state_q == WAIT) & bus.mem_rsp_valid & ~bus.redirect_valid;
  assign head_valid = (count_q != '0);
  assign pop        = head_valid & bus.inst_ready;
  assign count_d    = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.PCC           = fetch_pc_q;
  assign bus.inst_valid    = head_valid;
  assign bus.inst_data     = head_valid ? data_mem[rd_ptr_q] : '0;
  assign bus.inst_pc       = head_valid ? pc_mem[rd_ptr_q]   : '0;

  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= req_pc_q;
      data_mem[wr_ptr_q] <= bus.mem_rsp_data;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      fetch_pc_q      <= RESET_PC;
      req_pc_q        <= RESET_PC;
      mem_req_valid_q <= 1'b0;
      count_q         <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
    end else begin
      if (bus.redirect_valid) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        count_q <= count_d;
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end

      if (bus.redirect_valid) begin
        fetch_pc_q      <= {bus.redirect_pc[31:2], 2'b00};
        mem_req_valid_q <= 1'b0;
        // Anything already accepted by memory must have its response swallowed in DROP.
        case (state_q)
          IDLE:    state_q <= IDLE;
          REQ:     state_q <= accept ? DROP : IDLE;
          WAIT:    state_q <= bus.mem_rsp_valid ? IDLE : DROP;
          default: state_q <= bus.mem_rsp_valid ? IDLE : DROP;
        endcase
      end else begin
        case (state_q)
          IDLE: begin
            if (count_q < DEPTH_C) begin
              state_q         <= REQ;
              mem_req_valid_q <= 1'b1;
            end
          end
          REQ: begin
            if (accept) begin
              fetch_pc_q      <= fetch_pc_q + 32'd4;
              req_pc_q        <= fetch_pc_q;
              state_q         <= WAIT;
              mem_req_valid_q <= 1'b0;
            end
          end
          WAIT: begin
            if (bus.mem_rsp_valid) begin
              if (count_d < DEPTH_C) begin
                state_q         <= REQ;
                mem_req_valid_q <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: begin
            if (bus.mem_rsp_valid) state_q <= IDLE;
          end
        endcase
      end
    end
  end
endmodule
